// File: rtl/lfsr_seq_pkg.sv
// Shared types and helpers for the LFSR sequencer and its round-robin arbiter.
package lfsr_seq_pkg;

  localparam int LFSR_W = 128;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_WARM = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_t;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last granted one.
// Pointer moves only when the parent accepts the grant (i_advance).
module rr_arbiter
  import lfsr_seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_found;

  // Rotating-priority search starting one past the last granted requester.
  always_comb begin : p_search
    int c;
    c       = 0;
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = int'(r_ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!w_found && i_req[c]) begin
        w_found  = 1'b1;
        w_gnt[c] = 1'b1;
        w_idx    = IDX_W'(c);
      end
    end
  end

  // Last-granted pointer; reset to the top index so requester 0 wins first.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (i_advance && w_found) begin
      r_ptr <= w_idx;
    end
  end

  assign o_gnt = w_gnt;
  assign o_idx = w_idx;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer/arbiter in front of the 128-bit LFSR: seeds it, warms it up and
// hands random words to NUM_REQ requesters round-robin.
// Optional build macro LFSR_SEQ_STUCK_CHK_EN adds a sticky all-zero detector
// (o_stuck_err) that forces a reload of DEFAULT_SEED.
//
// state  | meaning
// S_LOAD | seed load pending / lfsr_load pulse being driven
// S_WARM | warm-up: LFSR stepping, counter runs down from WARMUP-1
// S_RUN  | ready; grant decision each cycle with a request
// S_STEP | extra LFSR steps after a grant (STEPS_PER_GRANT > 1)
module lfsr_seq_ctrl
  import lfsr_seq_pkg::*;
#(
  parameter int                NUM_REQ         = 4,
  parameter int                WIDTH           = LFSR_W,
  parameter int                WARMUP          = 16,
  parameter int                STEPS_PER_GRANT = 1,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED    = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_seed_wr,
  input  logic [WIDTH-1:0]   i_seed_in,
  output logic               o_seed_err,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [WIDTH-1:0]   o_rnd_data,
  output logic               o_ready,
  output logic               o_lfsr_enable,
  output logic               o_lfsr_load,
  output logic [WIDTH-1:0]   o_lfsr_seed,
`ifdef LFSR_SEQ_STUCK_CHK_EN
  output logic               o_stuck_err,
`endif
  input  logic [WIDTH-1:0]   i_lfsr_out
);

  localparam int CNT_MAX = (WARMUP > STEPS_PER_GRANT) ? WARMUP : STEPS_PER_GRANT;
  localparam int CNT_W   = clog2(CNT_MAX);
  localparam int IDX_W   = clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             r_state, w_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_seed, w_seed_nxt;
  logic [WIDTH-1:0]   r_rnd;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_load, r_en, r_ready, r_seed_err;
  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_valid, w_seed_ok, w_seed_zero, w_stuck, w_fire;

  assign w_seed_ok   = i_seed_wr && (i_seed_in != '0);
  assign w_seed_zero = i_seed_wr && (i_seed_in == '0);
  assign w_arb_valid = |w_arb_gnt;

`ifdef LFSR_SEQ_STUCK_CHK_EN
  logic r_stuck_err;
  assign w_stuck = ((r_state == S_RUN) || (r_state == S_STEP)) && (i_lfsr_out == '0);

  // Sticky stuck-at-zero flag, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_stuck_err <= 1'b0;
    else if (w_stuck) r_stuck_err <= 1'b1;
  end

  assign o_stuck_err = r_stuck_err;
`else
  assign w_stuck = 1'b0;
`endif

  // A reload (requested or forced) always beats a grant decided in the same cycle.
  assign w_fire = (r_state == S_RUN) && w_arb_valid && !w_seed_ok && !w_stuck;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_req     (i_req),
    .i_advance (w_fire),
    .o_gnt     (w_arb_gnt),
    .o_idx     (w_arb_idx)
  );

  // Next-state, counter and seed selection.
  always_comb begin
    w_nxt      = r_state;
    w_cnt_nxt  = r_cnt;
    w_seed_nxt = r_seed;
    case (r_state)
      S_LOAD: begin
        // r_load marks that the load pulse is already on the LFSR pins.
        if (r_load) begin
          w_nxt     = S_WARM;
          w_cnt_nxt = CNT_W'(WARMUP - 1);
        end
      end
      S_WARM: begin
        if (r_cnt == '0) w_nxt = S_RUN;
        else w_cnt_nxt = r_cnt - CNT_ONE;
      end
      S_RUN: begin
        if (w_fire && (STEPS_PER_GRANT > 1)) begin
          w_nxt     = S_STEP;
          w_cnt_nxt = CNT_W'(STEPS_PER_GRANT - 2);
        end
      end
      S_STEP: begin
        if (r_cnt == '0) w_nxt = S_RUN;
        else w_cnt_nxt = r_cnt - CNT_ONE;
      end
      default: w_nxt = S_LOAD;
    endcase
    if (w_stuck) begin
      w_nxt      = S_LOAD;
      w_seed_nxt = DEFAULT_SEED;
    end
    if (w_seed_ok) begin
      w_nxt      = S_LOAD;
      w_seed_nxt = i_seed_in;
    end
  end

  // State, counter and registered outputs derived from the next state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_LOAD;
      r_cnt      <= '0;
      r_seed     <= DEFAULT_SEED;
      r_load     <= 1'b0;
      r_en       <= 1'b0;
      r_ready    <= 1'b0;
      r_seed_err <= 1'b0;
      r_gnt      <= '0;
      r_rnd      <= '0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_seed     <= w_seed_nxt;
      r_load     <= (w_nxt == S_LOAD);
      r_en       <= (w_nxt == S_WARM) || (w_nxt == S_STEP);
      r_ready    <= (w_nxt == S_RUN) || (w_nxt == S_STEP);
      r_seed_err <= w_seed_zero;
      r_gnt      <= w_fire ? (NUM_REQ'(1) << w_arb_idx) : '0;
      if (w_fire) r_rnd <= i_lfsr_out;
    end
  end

  // The grant cycle itself steps the LFSR so back-to-back grants get fresh words.
  assign o_lfsr_enable = r_en | w_fire;
  assign o_lfsr_load   = r_load;
  assign o_lfsr_seed   = r_seed;
  assign o_ready       = r_ready;
  assign o_gnt         = r_gnt;
  assign o_rnd_data    = r_rnd;
  assign o_seed_err    = r_seed_err;

endmodule
